// File: rtl/stream_demux_1_4_pkg.sv
// Shared types for the 1-to-4 stream demultiplexer: port count, selector type
// and packet-lock FSM states.
package stream_demux_1_4_pkg;

  localparam int N_PORTS = 4;

  typedef logic [1:0] sel_t;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

endpackage

// File: rtl/demux_out_slot.sv
// One-entry downstream output slot; outputs come straight from the slot
// registers, and a full slot can be drained and refilled on the same edge.
module demux_out_slot #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             wr_last_i,
  input  logic             rd_ready_i,
  output logic             free_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             last_o
);

  logic             valid_q;
  logic [WIDTH-1:0] data_q;
  logic             last_q;

  assign free_o  = ~valid_q | rd_ready_i;
  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign last_o  = last_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
    end else if (wr_en_i) begin
      valid_q <= 1'b1;
    end else if (rd_ready_i) begin
      valid_q <= 1'b0;
    end
  end

  // Payload carries no reset; it is only observed while valid_q is set.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      data_q <= wr_data_i;
      last_q <= wr_last_i;
    end
  end

endmodule

// File: rtl/stream_demux_1_4.sv
// 1-to-4 packet stream demultiplexer: a packet is routed by the up_sel of its
// first beat. Optional per-destination beat counters: STREAM_DEMUX_1_4_CNT_EN.
module stream_demux_1_4
  import stream_demux_1_4_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            up_valid,
  output logic                            up_ready,
  input  logic [WIDTH-1:0]                up_data,
  input  sel_t                            up_sel,
  input  logic                            up_last,
  output logic [N_PORTS-1:0]              dn_valid,
  input  logic [N_PORTS-1:0]              dn_ready,
  output logic [N_PORTS-1:0][WIDTH-1:0]   dn_data,
  output logic [N_PORTS-1:0]              dn_last
`ifdef STREAM_DEMUX_1_4_CNT_EN
  ,
  output logic [N_PORTS-1:0][7:0]         beat_cnt
`endif
);

  state_e               state_q, state_d;
  sel_t                 lock_q, lock_d;
  sel_t                 dest;
  logic                 accept;
  logic [N_PORTS-1:0]   slot_free;
  logic [N_PORTS-1:0]   wr_en;

  // Mid-packet, the destination is frozen to the channel of the first beat.
  assign dest     = (state_q == LOCKED) ? lock_q : up_sel;
  assign up_ready = slot_free[dest];
  assign accept   = up_valid & up_ready;

  always_comb begin
    wr_en = '0;
    if (accept) begin
      wr_en[dest] = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    lock_d  = lock_q;
    case (state_q)
      IDLE: begin
        if (accept && !up_last) begin
          state_d = LOCKED;
          lock_d  = up_sel;
        end
      end
      LOCKED: begin
        if (accept && up_last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      lock_q  <= '0;
    end else begin
      state_q <= state_d;
      lock_q  <= lock_d;
    end
  end

  for (genvar g = 0; g < N_PORTS; g++) begin : g_slot
    demux_out_slot #(
      .WIDTH(WIDTH)
    ) u_slot (
      .clk       (clk),
      .rst       (rst),
      .wr_en_i   (wr_en[g]),
      .wr_data_i (up_data),
      .wr_last_i (up_last),
      .rd_ready_i(dn_ready[g]),
      .free_o    (slot_free[g]),
      .valid_o   (dn_valid[g]),
      .data_o    (dn_data[g]),
      .last_o    (dn_last[g])
    );
  end

`ifdef STREAM_DEMUX_1_4_CNT_EN
  logic [N_PORTS-1:0][7:0] cnt_q;

  // Counters wrap naturally at 8 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < N_PORTS; i++) begin
        if (wr_en[i]) begin
          cnt_q[i] <= cnt_q[i] + 8'd1;
        end
      end
    end
  end

  assign beat_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_stream_demux_1_4.sv
// Scoreboard bench for stream_demux_1_4: a reference model queues expected
// beats per channel; a monitor pops and compares as channels drain.
module tb_stream_demux_1_4;

  logic             clk = 1'b0;
  logic             rst;
  logic             up_valid;
  logic             up_ready;
  logic [3:0]       up_data;
  logic [1:0]       up_sel;
  logic             up_last;
  logic [3:0]       dn_valid;
  logic [3:0]       dn_ready;
  logic [3:0][3:0]  dn_data;
  logic [3:0]       dn_last;
`ifdef STREAM_DEMUX_1_4_CNT_EN
  logic [3:0][7:0]  beat_cnt;
`endif

  stream_demux_1_4 #(.WIDTH(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .up_valid(up_valid),
    .up_ready(up_ready),
    .up_data (up_data),
    .up_sel  (up_sel),
    .up_last (up_last),
    .dn_valid(dn_valid),
    .dn_ready(dn_ready),
    .dn_data (dn_data),
    .dn_last (dn_last)
`ifdef STREAM_DEMUX_1_4_CNT_EN
    ,
    .beat_cnt(beat_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] d;
    logic       l;
  } beat_t;

  beat_t q[4][$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    exp_cnt[4];
  bit    rand_rdy = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a packet goes wherever its first beat's sel pointed.
  initial begin : model
    bit    in_pkt;
    int    lock_ch;
    int    dest;
    bit    acc;
    bit    was_rst;
    beat_t pb;
    int    pd;
    in_pkt  = 1'b0;
    lock_ch = 0;
    forever begin
      @(negedge clk);
      acc     = 1'b0;
      was_rst = rst;
      if (!rst) begin
        dest = in_pkt ? lock_ch : int'(up_sel);
        chk("up_ready", {31'd0, up_ready},
            {31'd0, (q[dest].size() == 0) || dn_ready[dest]});
        if (up_valid && up_ready) begin
          acc = 1'b1;
          pb  = '{d: up_data, l: up_last};
          pd  = dest;
          if (!in_pkt && !up_last) begin
            in_pkt  = 1'b1;
            lock_ch = int'(up_sel);
          end else if (in_pkt && up_last) begin
            in_pkt = 1'b0;
          end
        end
      end
      @(posedge clk);
      #1;
      if (was_rst) begin
        for (int i = 0; i < 4; i++) begin
          q[i].delete();
          exp_cnt[i] = 0;
        end
        in_pkt  = 1'b0;
        lock_ch = 0;
      end else if (acc) begin
        q[pd].push_back(pb);
        exp_cnt[pd] = (exp_cnt[pd] + 1) % 256;
      end
    end
  end

  // Monitor: slot contents must match the model queue every cycle.
  initial begin : monitor
    beat_t f;
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        for (int i = 0; i < 4; i++) begin
          chk($sformatf("dn_valid[%0d]", i), {31'd0, dn_valid[i]}, {31'd0, q[i].size() != 0});
          if (dn_valid[i] && q[i].size() != 0) begin
            f = q[i][0];
            chk($sformatf("dn_data[%0d]", i), {28'd0, dn_data[i]}, {28'd0, f.d});
            chk($sformatf("dn_last[%0d]", i), {31'd0, dn_last[i]}, {31'd0, f.l});
            if (dn_ready[i]) void'(q[i].pop_front());
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] d, input logic [1:0] s, input logic l, output int waits);
    bit got;
    up_valid = 1'b1;
    up_data  = d;
    up_sel   = s;
    up_last  = l;
    waits    = 0;
    forever begin
      @(negedge clk);
      got = up_ready;
      @(posedge clk);
      #1;
      if (rand_rdy) dn_ready = 4'($urandom);
      if (got) break;
      waits++;
      if (waits > 50) begin
        chk("send_timeout", 32'd1, 32'd0);
        break;
      end
    end
    up_valid = 1'b0;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 500000");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int w;
    logic [3:0] sd;
    rst      = 1'b1;
    up_valid = 1'b0;
    up_data  = '0;
    up_sel   = '0;
    up_last  = 1'b0;
    dn_ready = 4'h0;
    tick(2);
    @(negedge clk);
    chk("rst_dn_valid", {28'd0, dn_valid}, 32'd0);
    chk("rst_up_ready", {31'd0, up_ready}, 32'd1);
    tick(1);
    rst = 1'b0;
    tick(1);

    // Single-beat packets to every channel.
    dn_ready = 4'hf;
    for (int i = 0; i < 4; i++) begin
      send(4'(4'ha + i), 2'(i), 1'b1, w);
      chk("single_waits", w, 0);
    end
    tick(2);

    // Locked packet: sel changes after the first beat are ignored.
    send(4'h1, 2'd2, 1'b0, w);
    send(4'h2, 2'd0, 1'b0, w);
    send(4'h3, 2'd0, 1'b1, w);
    tick(2);

    // Backpressure on channel 1 while other channels keep flowing.
    dn_ready = 4'b1101;
    send(4'h8, 2'd1, 1'b1, w);
    up_valid = 1'b1;
    up_data  = 4'h9;
    up_sel   = 2'd1;
    up_last  = 1'b1;
    @(negedge clk);
    chk("bp_up_ready", {31'd0, up_ready}, 32'd0);
    tick(1);
    up_valid = 1'b0;
    send(4'he, 2'd3, 1'b1, w);
    chk("bp_other_waits", w, 0);
    dn_ready = 4'hf;
    send(4'h9, 2'd1, 1'b1, w);
    chk("bp_release_waits", w, 0);
    tick(2);

    // Full slot drained and refilled on the same edge, no bubbles.
    dn_ready = 4'b1110;
    send(4'h5, 2'd0, 1'b1, w);
    dn_ready = 4'hf;
    for (int i = 0; i < 4; i++) begin
      send(4'(i + 6), 2'd0, 1'b1, w);
      chk("b2b_waits", w, 0);
    end
    tick(2);

    // Reset in the middle of a packet discards the beat and the lock.
    dn_ready = 4'b1101;
    send(4'h1, 2'd1, 1'b0, w);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_dn_valid", {28'd0, dn_valid}, 32'd0);
    tick(1);
    dn_ready = 4'hf;
    send(4'h7, 2'd3, 1'b1, w);
    tick(3);

    // Randomized traffic with random downstream backpressure.
    rand_rdy = 1'b1;
    for (int n = 0; n < 300; n++) begin
      sd = 4'($urandom);
      send(sd, 2'($urandom), ($urandom_range(0, 2) == 0), w);
      if ($urandom_range(0, 3) == 0) begin
        tick(1);
        dn_ready = 4'($urandom);
      end
    end
    rand_rdy = 1'b0;
    dn_ready = 4'hf;
    send(4'h0, 2'd0, 1'b1, w);
    tick(3);
    @(negedge clk);
    chk("drain_dn_valid", {28'd0, dn_valid}, 32'd0);
    tick(1);

`ifdef STREAM_DEMUX_1_4_CNT_EN
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(1);
    for (int n = 0; n < 257; n++) begin
      send(4'(n), 2'd0, 1'b1, w);
    end
    tick(2);
    chk("cnt_wrap0", {24'd0, beat_cnt[0]}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("beat_cnt[%0d]", i), {24'd0, beat_cnt[i]}, exp_cnt[i]);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/stream_demux_1_4.md
STREAM_DEMUX_1_4 -- requirements
Module: stream_demux_1_4

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, meaning the data width of the upstream and each downstream channel.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, a synchronous active-high reset.
REQ-004 The block SHALL have ports up_valid (input, 1), up_ready (output, 1), up_data (input, WIDTH), up_sel (input, 2) and up_last (input, 1), forming the upstream beat, destination index and end-of-packet flag.
REQ-005 The block SHALL have ports dn_valid (output, 4), dn_ready (input, 4) and dn_data (output, 4 x WIDTH); downstream channel i uses bit or element i.
REQ-006 The block SHALL have port dn_last, output, 4, the per-channel end-of-packet flag.

Function
REQ-007 A beat SHALL transfer on any interface in a cycle where valid and ready are both 1 at the rising edge of clk.
REQ-008 Each downstream channel SHALL hold a one-entry output slot; dn_valid, dn_data and dn_last SHALL come directly from slot registers.
REQ-009 Latency from upstream acceptance to dn_valid[d] = 1 SHALL be exactly one cycle.
REQ-010 up_ready SHALL be 1 when the slot of destination d is empty, or when it is full and dn_ready[d] = 1 in the same cycle; a full slot SHALL be drained and refilled in the same edge.
REQ-011 Destination d SHALL be up_sel while the FSM is in IDLE, and the locked index while it is in LOCKED.
REQ-012 The FSM SHALL have two states, IDLE and LOCKED.
REQ-013 IDLE SHALL move to LOCKED on an accepted beat with up_last = 0 and capture up_sel as the locked index.
REQ-014 LOCKED SHALL return to IDLE on an accepted beat with up_last = 1.
REQ-015 An accepted beat with up_last = 1 in IDLE SHALL leave the FSM in IDLE, as a single-beat packet.
REQ-016 up_sel changes while in LOCKED SHALL be ignored.
REQ-017 A non-destination channel SHALL never stall the upstream, and channels SHALL drain independently.
REQ-018 dn_data[i] and dn_last[i] SHALL hold their value while dn_valid[i] = 1 and dn_ready[i] = 0.
REQ-019 up_ready SHALL be independent of up_valid.
REQ-020 When up_valid = 0, no slot SHALL be written.

Reset
REQ-021 While rst = 1, dn_valid SHALL be 4'b0000, the FSM SHALL be IDLE, the locked index SHALL be 0, and up_ready SHALL reflect empty slots (1).
REQ-022 dn_data and dn_last SHALL not be required to reset.
REQ-023 Reset mid-packet SHALL discard all buffered beats and the lock, with no partial-packet completion after release.

Configuration
REQ-024 With macro STREAM_DEMUX_1_4_CNT_EN defined, the block SHALL add output port beat_cnt, 4 x 8 bits, counting accepted upstream beats per destination.
REQ-025 beat_cnt SHALL wrap from 255 to 0, reset to 0, and increment on the acceptance edge.
REQ-026 Without STREAM_DEMUX_1_4_CNT_EN, the port and counters SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-027 Package stream_demux_1_4_pkg SHALL hold N_PORTS = 4, the 2-bit sel typedef and the IDLE/LOCKED state enum.
REQ-028 The output slot SHALL be a sub-module named demux_out_slot (parameter WIDTH), instantiated four times.

Verification
REQ-029 The bench SHALL cover single beats: data 4'ha/b/c/d with sel 0/1/2/3 and up_last = 1, all dn_ready = 1 -> dn_data[i] equals the sent value one cycle later, up_ready stays 1.
REQ-030 The bench SHALL cover a locked packet: sel = 2 with 3 beats 4'h1, 4'h2, 4'h3 (last on the third), sel driven to 0 after the first beat -> all three beats appear on channel 2 only, and dn_last[2] = 1 on 4'h3.
REQ-031 The bench SHALL cover backpressure: dn_ready[1] = 0, two beats to sel 1 -> first held in the slot, up_ready = 0 on the second; a beat to sel 3 still passes when the FSM is IDLE.
REQ-032 The bench SHALL cover same-cycle drain and refill: slot 0 full, dn_ready[0] = 1, a new beat to sel 0 -> up_ready = 1, with back-to-back transfers at one beat per cycle and no bubble.
REQ-033 The bench SHALL cover reset mid-packet: rst asserted after the first of 3 beats to sel 1 -> dn_valid = 0 and the FSM IDLE next cycle, and the next beat with sel 3 routes to channel 3.
REQ-034 With STREAM_DEMUX_1_4_CNT_EN defined, the bench SHALL cover counter wrap: 257 beats to sel 0 -> beat_cnt[0] = 1 and the other counters = 0.
